// File: rtl/truth_table_scanner_pkg.sv
// rtl/truth_table_scanner_pkg.sv - shared types and sizing for the truth table scanner
package truth_table_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = $clog2(SETTLE_MAX + 1);

  function automatic int row_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// rtl/truth_table_scanner_if.sv - scanner control, stimulus and result bundle
interface truth_table_scanner_if
  import truth_table_pkg::*;
#(
  parameter int N_IN = 4
);
  localparam int ROWS = row_count(N_IN);

  logic            start;
  logic            abort;
  logic            resp;
  logic [ROWS-1:0] expected;
  logic [N_IN-1:0] stim;
  logic [ROWS-1:0] table_out;
  logic            busy;
  logic            done;
  logic            match;

  modport master (
    output start, abort, resp, expected,
    input  stim, table_out, busy, done, match
  );

  modport slave (
    input  start, abort, resp, expected,
    output stim, table_out, busy, done, match
  );

endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// rtl/truth_table_scanner_settle_timer.sv - loadable settle down-counter
module settle_timer
  import truth_table_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the last settle cycle so the FSM enters SAMPLE on the next edge.
  assign expired = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - exhaustive truth table scan of a small combinational DUT
module truth_table_scanner
  import truth_table_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int SETTLE_CYC = 1
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_scanner_if.slave bus
);

  localparam int              ROWS     = row_count(N_IN);
  localparam logic [N_IN-1:0] LAST_ROW = N_IN'(ROWS - 1);

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [ROWS-1:0] table_q, table_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            match_q, match_d;
  logic            timer_load;
  logic            timer_expired;

  settle_timer u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .value   (CNT_W'(SETTLE_CYC)),
    .expired (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    table_d    = table_q;
    done_d     = 1'b0;
    match_d    = match_q;
    timer_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          table_d = '0;
          match_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        timer_load = 1'b1;
        state_d    = (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timer_expired) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        table_d[idx_q] = bus.resp;
        if (idx_q == LAST_ROW) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + N_IN'(1);
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        match_d = (table_q == bus.expected);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort keeps the partial column so software can inspect how far the scan got.
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      table_d    = table_q;
      done_d     = 1'b0;
      match_d    = 1'b0;
      timer_load = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign bus.stim      = idx_q;
  assign bus.table_out = table_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.match     = match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - directed self-checking bench for truth_table_scanner
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic rst3;
  logic rst4;
  logic mode3;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  truth_table_scanner_if #(.N_IN(3)) if3 ();
  truth_table_scanner_if #(.N_IN(4)) if4 ();

  truth_table_scanner #(.N_IN(3), .SETTLE_CYC(1)) u3 (
    .clk (clk),
    .rst (rst3),
    .bus (if3)
  );

  truth_table_scanner #(.N_IN(4), .SETTLE_CYC(0)) u4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4)
  );

  // Device under scan: 3-input AND (or stim[0] for the abort case), 4-input XOR
  assign if3.resp = mode3 ? if3.stim[0] : (&if3.stim);
  assign if4.resp = ^if4.stim;

  task automatic test_reset();
    @(negedge clk);
    rst3 = 1'b1;
    rst4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if3.stim, if3.table_out, if3.busy, if3.done, if3.match} !== 14'h0) begin
      failures++;
      $display("FAIL reset_u3 got stim=%h tab=%h busy=%b done=%b match=%b want all 0",
               if3.stim, if3.table_out, if3.busy, if3.done, if3.match);
    end
    checks++;
    if ({if4.stim, if4.table_out, if4.busy, if4.done, if4.match} !== 23'h0) begin
      failures++;
      $display("FAIL reset_u4 got stim=%h tab=%h busy=%b done=%b match=%b want all 0",
               if4.stim, if4.table_out, if4.busy, if4.done, if4.match);
    end
    rst3 = 1'b0;
    rst4 = 1'b0;
  endtask

  task automatic scan3(input string name, input bit repulse,
                       input logic [7:0] exp_tab, input logic exp_match);
    int ndone, done_k, stim_err, busy_err;
    logic [2:0] exp_stim;
    ndone = 0; done_k = -1; stim_err = 0; busy_err = 0;
    @(negedge clk);
    if3.start = 1'b1;
    @(posedge clk);
    #1;
    if3.start = 1'b0;
    checks++;
    if (if3.busy !== 1'b1 || if3.match !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept got busy=%b match=%b want busy=1 match=0", name, if3.busy, if3.match);
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (repulse) if3.start = (k == 6 || k == 15);
      if (if3.done === 1'b1) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      exp_stim = (k / 3 > 7) ? 3'd7 : 3'(k / 3);
      if (k < 25 && if3.stim !== exp_stim) stim_err++;
      if (k < 25 && if3.busy !== 1'b1) busy_err++;
      if (k == 25) begin
        checks++;
        if (if3.table_out !== exp_tab || if3.match !== exp_match || if3.stim !== 3'd7 || if3.busy !== 1'b0) begin
          failures++;
          $display("FAIL %s_result got tab=%h match=%b stim=%0d busy=%b want tab=%h match=%b stim=7 busy=0",
                   name, if3.table_out, if3.match, if3.stim, if3.busy, exp_tab, exp_match);
        end
      end
    end
    if3.start = 1'b0;
    checks++;
    if (done_k !== 25 || ndone !== 1) begin
      failures++;
      $display("FAIL %s_done_timing got cycle=%0d pulses=%0d want cycle=25 pulses=1", name, done_k, ndone);
    end
    checks++;
    if (stim_err !== 0 || busy_err !== 0) begin
      failures++;
      $display("FAIL %s_sequence got stim_err=%0d busy_err=%0d want 0 0", name, stim_err, busy_err);
    end
    checks++;
    if (if3.match !== exp_match) begin
      failures++;
      $display("FAIL %s_match_hold got %b want %b", name, if3.match, exp_match);
    end
  endtask

  task automatic scan4(input string name, input logic [15:0] exp_in,
                       input logic [15:0] exp_tab, input logic exp_match);
    int ndone, done_k, stim_err;
    logic [3:0] exp_stim;
    ndone = 0; done_k = -1; stim_err = 0;
    @(negedge clk);
    if4.expected = exp_in;
    if4.start    = 1'b1;
    @(posedge clk);
    #1;
    if4.start = 1'b0;
    checks++;
    if (if4.busy !== 1'b1 || if4.match !== 1'b0 || if4.table_out !== 16'h0) begin
      failures++;
      $display("FAIL %s_accept got busy=%b match=%b tab=%h want 1 0 0000", name, if4.busy, if4.match, if4.table_out);
    end
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (if4.done === 1'b1) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      exp_stim = (k / 2 > 15) ? 4'd15 : 4'(k / 2);
      if (k < 33 && if4.stim !== exp_stim) stim_err++;
      if (k == 33) begin
        checks++;
        if (if4.table_out !== exp_tab || if4.match !== exp_match || if4.stim !== 4'd15) begin
          failures++;
          $display("FAIL %s_result got tab=%h match=%b stim=%0d want tab=%h match=%b stim=15",
                   name, if4.table_out, if4.match, if4.stim, exp_tab, exp_match);
        end
      end
    end
    checks++;
    if (done_k !== 33 || ndone !== 1 || stim_err !== 0) begin
      failures++;
      $display("FAIL %s_done_timing got cycle=%0d pulses=%0d stim_err=%0d want 33 1 0", name, done_k, ndone, stim_err);
    end
  endtask

  task automatic test_and3();
    scan3("and3", 1'b0, 8'h80, 1'b1);
  endtask

  task automatic test_xor4();
    scan4("xor4_ok", 16'h6996, 16'h6996, 1'b1);
    scan4("xor4_bad", 16'h6997, 16'h6996, 1'b0);
  endtask

  task automatic test_back_to_back();
    scan3("restart", 1'b1, 8'h80, 1'b1);
  endtask

  task automatic test_abort();
    int ndone;
    ndone = 0;
    mode3 = 1'b1;
    @(negedge clk);
    if3.start = 1'b1;
    @(posedge clk);
    #1;
    if3.start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (if3.stim !== 3'd4 || if3.busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre got stim=%0d busy=%b want 4 1", if3.stim, if3.busy);
    end
    if3.abort = 1'b1;
    @(posedge clk);
    #1;
    if3.abort = 1'b0;
    checks++;
    if (if3.busy !== 1'b0 || if3.stim !== 3'd0 || if3.done !== 1'b0 || if3.match !== 1'b0 || if3.table_out !== 8'h0A) begin
      failures++;
      $display("FAIL abort_state got busy=%b stim=%0d done=%b match=%b tab=%h want 0 0 0 0 0a",
               if3.busy, if3.stim, if3.done, if3.match, if3.table_out);
    end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (if3.done === 1'b1 || if3.busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL abort_quiet got active_cycles=%0d want 0", ndone);
    end
    mode3 = 1'b0;
    scan3("post_abort", 1'b0, 8'h80, 1'b1);
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    @(negedge clk);
    if4.expected = 16'h6996;
    if4.start    = 1'b1;
    @(posedge clk);
    #1;
    if4.start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (if4.stim !== 4'd9 || if4.table_out !== 16'h0196) begin
      failures++;
      $display("FAIL rst_pre got stim=%0d tab=%h want 9 0196", if4.stim, if4.table_out);
    end
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    checks++;
    if ({if4.stim, if4.table_out, if4.busy, if4.done, if4.match} !== 23'h0) begin
      failures++;
      $display("FAIL rst_mid got stim=%h tab=%h busy=%b done=%b match=%b want all 0",
               if4.stim, if4.table_out, if4.busy, if4.done, if4.match);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (if4.done === 1'b1 || if4.busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL rst_quiet got active_cycles=%0d want 0", ndone);
    end
    @(negedge clk);
    if4.start = 1'b1;
    if4.abort = 1'b1;
    @(posedge clk);
    #1;
    if4.start = 1'b0;
    if4.abort = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (if4.busy !== 1'b0 || if4.stim !== 4'd0) begin
      failures++;
      $display("FAIL start_abort got busy=%b stim=%0d want 0 0", if4.busy, if4.stim);
    end
    scan4("post_rst", 16'h6996, 16'h6996, 1'b1);
  endtask

  initial begin
    rst3 = 1'b1;
    rst4 = 1'b1;
    mode3 = 1'b0;
    if3.start = 1'b0;
    if3.abort = 1'b0;
    if3.expected = 8'h80;
    if4.start = 1'b0;
    if4.abort = 1'b0;
    if4.expected = 16'h6996;
    test_reset();
    test_and3();
    test_xor4();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter N_IN, default 4, sets the number of DUT inputs driven (legal 1..6).
REQ-002 Parameter SETTLE_CYC, default 1, sets the wait cycles between applying a row and sampling it (legal 0..15).
REQ-003 Port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port start, input, 1, begins an exhaustive scan when sampled high in IDLE.
REQ-006 Port abort, input, 1, cancels a scan in progress.
REQ-007 Port resp, input, 1, DUT output (LED) under test.
REQ-008 Port expected, input, 2^N_IN, golden output column; bit i is the expected output for row i.
REQ-009 Port stim, output, N_IN, DUT input vector; stim[N_IN-1] is input A (MSB), stim[0] is the last input.
REQ-010 Port table_out, output, 2^N_IN, captured output column; bit i is resp sampled for row i.
REQ-011 Port busy, output, 1, high from the cycle after start is accepted until DONE is left.
REQ-012 Port done, output, 1, one-cycle pulse marking scan completion.
REQ-013 Port match, output, 1, high when table_out equals expected; valid on done and held until the next start.

Function
REQ-014 The FSM shall have states IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE with start=1 shall go to DRIVE, clear row index idx and table_out to 0, and clear match.
REQ-016 stim shall equal the registered idx, so it changes only on the edge that leaves SAMPLE or when idx is cleared.
REQ-017 DRIVE shall last 1 cycle, load the settle counter with SETTLE_CYC, and go to SETTLE, or to SAMPLE when SETTLE_CYC=0.
REQ-018 SETTLE shall decrement the counter each cycle and go to SAMPLE on the cycle it reads 1.
REQ-019 SAMPLE shall write table_out[idx] <= resp.
REQ-020 After SAMPLE, if idx = 2^N_IN-1 the FSM shall go to DONE; otherwise it shall increment idx and go to DRIVE.
REQ-021 Each row shall take SETTLE_CYC+2 cycles, and done shall rise 2^N_IN*(SETTLE_CYC+2)+1 cycles after the start-accept edge.
REQ-022 DONE shall last 1 cycle with done=1 and match registered as (table_out == expected) including the final row, then return to IDLE.
REQ-023 start while busy or in DONE shall be ignored.
REQ-024 abort in any non-IDLE state shall return to IDLE next cycle with done=0, match=0, idx=0, and table_out holding the partial column.
REQ-025 abort shall take priority over state progression, and rst shall take priority over abort.
REQ-026 start and abort both high in IDLE shall leave the FSM in IDLE.
REQ-027 idx shall never wrap; the last row shall exit to DONE, never to row 0.
REQ-028 expected shall be sampled only in DONE and may change at any other time.

Reset
REQ-029 On rst=1 at a clock edge, the FSM shall go to IDLE with idx=0, stim=0, table_out=0, busy=0, done=0, match=0 and settle counter=0, regardless of state.
REQ-030 rst asserted mid-scan shall produce no done pulse, and the next start shall run a full scan from row 0.

Structure
REQ-031 The state enumeration, the SETTLE_CYC maximum and the row-count helper (2^N_IN) shall live in shared package truth_table_pkg.
REQ-032 The settle down-counter shall be sub-module settle_timer (inputs load, value; output expired), instantiated once.
REQ-033 The design shall contain no latches, no combinational path from resp to any output, and only registered outputs.

Verification
REQ-034 N_IN=3, SETTLE_CYC=1, DUT=3-input AND, expected=8'h80, start pulse -> stim steps 0..7, done at cycle 25, table_out=8'h80, match=1.
REQ-035 N_IN=4, SETTLE_CYC=0, DUT=4-input XOR, expected=16'h6996 -> done at cycle 33, table_out=16'h6996, match=1; repeat with expected=16'h6997 -> match=0.
REQ-036 N_IN=3, start re-pulsed at rows 2 and 5 -> a single scan and a single done pulse, with timing identical to REQ-034.
REQ-037 N_IN=3, abort during row 4 SETTLE -> IDLE next cycle, stim=0, no done, table_out[7:4]=0; a new start gives a correct full scan.
REQ-038 N_IN=4, rst during row 9 -> all outputs 0 next cycle, no done; start and abort together in IDLE -> busy stays 0.
